// File: rtl/graphics_pkg.sv
// Shared pattern codes, sequencer state encoding and pattern helpers
// for the display graphics blocks.
package graphics_pkg;

    typedef logic [2:0] pat_t;

    localparam pat_t PAT_BLUE   = 3'd0;
    localparam pat_t PAT_RED    = 3'd1;
    localparam pat_t PAT_GREEN  = 3'd2;
    localparam pat_t PAT_SMILE  = 3'd3;
    localparam pat_t PAT_PIRATE = 3'd4;
    localparam pat_t PAT_DISCO  = 3'd5;
    localparam pat_t PAT_LAST   = 3'd5;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } seq_state_e;

    // Switch codes past the last pattern fall back to blue.
    function automatic pat_t pat_sanitize(input logic [2:0] sw);
        return (sw > PAT_LAST) ? PAT_BLUE : sw;
    endfunction

    function automatic pat_t pat_next(input pat_t p);
        return (p >= PAT_LAST) ? PAT_BLUE : pat_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Signal bundle between a pattern source (master) and the
// pattern sequencer (slave).
interface pattern_sequencer_if;
    import graphics_pkg::*;

    logic       vertSync;
    logic [2:0] swMode;
    logic       autoEnable;
    logic       btnStep;
    pat_t       patternSel;
    logic       frameTick;
    logic       autoActive;

    modport master (
        output vertSync, swMode, autoEnable, btnStep,
        input  patternSel, frameTick, autoActive
    );

    modport slave (
        input  vertSync, swMode, autoEnable, btnStep,
        output patternSel, frameTick, autoActive
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: one-cycle press pulse after CYCLES stable-high
// clocks, re-armed only once the button reads low again.
module btn_debounce #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_in};
        cnt_d   = cnt_q;
        done_d  = done_q;
        press_d = 1'b0;
        if (!sync_q[1]) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (!done_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                press_d = 1'b1;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern selector; PATTERN_SEQ_AUTO_CYCLE_EN adds
// the auto-cycle mode with frame counting and a debounced step button.
module pattern_sequencer
    import graphics_pkg::*;
#(
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned DEBOUNCE_CYCLES    = 1000000
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       vertSync,
    input  logic [2:0] swMode,
    input  logic       autoEnable,
    input  logic       btnStep,
    output logic [2:0] patternSel,
    output logic       frameTick,
    output logic       autoActive
);

    logic vs_prev_q, vs_prev_d;
    logic armed_q, armed_d;
    logic tick_q, tick_d;
    pat_t pat_q, pat_d;

    // armed_q masks the first sample after reset, whose "previous" is synthetic.
    always_comb begin
        vs_prev_d = vertSync;
        armed_d   = 1'b1;
        tick_d    = armed_q & vs_prev_q & ~vertSync;
    end

`ifdef PATTERN_SEQ_AUTO_CYCLE_EN

    seq_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        step_q, step_d;
    logic        press;

    btn_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (CLK100MHZ),
        .rst    (reset),
        .btn_in (btnStep),
        .press  (press)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        pat_d   = pat_q;
        if (tick_q) begin
            unique case (state_q)
                ST_MANUAL: begin
                    if (autoEnable) begin
                        state_d = ST_AUTO;
                        cnt_d   = '0;
                    end else begin
                        pat_d = pat_sanitize(swMode);
                    end
                end
                ST_AUTO: begin
                    if (!autoEnable) begin
                        state_d = ST_MANUAL;
                        pat_d   = pat_sanitize(swMode);
                        cnt_d   = '0;
                        step_d  = 1'b0;
                    end else if (step_q ||
                                 cnt_q == 16'(FRAMES_PER_PATTERN - 1)) begin
                        pat_d  = pat_next(pat_q);
                        cnt_d  = '0;
                        step_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_MANUAL;
            endcase
        end
        if (press && state_q == ST_AUTO && state_d == ST_AUTO) begin
            step_d = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q <= ST_MANUAL;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    assign autoActive = (state_q == ST_AUTO);

`else

    logic unused_inputs;
    assign unused_inputs = ^{autoEnable, btnStep};

    always_comb begin
        pat_d = tick_q ? pat_sanitize(swMode) : pat_q;
    end

    assign autoActive = 1'b0;

`endif

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            vs_prev_q <= 1'b1;
            armed_q   <= 1'b0;
            tick_q    <= 1'b0;
            pat_q     <= PAT_BLUE;
        end else begin
            vs_prev_q <= vs_prev_d;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            pat_q     <= pat_d;
        end
    end

    assign patternSel = pat_q;
    assign frameTick  = tick_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer (FRAMES_PER_PATTERN=3,
// DEBOUNCE_CYCLES=4); auto-mode vectors follow PATTERN_SEQ_AUTO_CYCLE_EN.
module tb_pattern_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   tick_cnt = 0;
    int   tick_base;

    pattern_sequencer_if sif ();

    pattern_sequencer #(
        .FRAMES_PER_PATTERN (3),
        .DEBOUNCE_CYCLES    (4)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (rst),
        .vertSync   (sif.vertSync),
        .swMode     (sif.swMode),
        .autoEnable (sif.autoEnable),
        .btnStep    (sif.btnStep),
        .patternSel (sif.patternSel),
        .frameTick  (sif.frameTick),
        .autoActive (sif.autoActive)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sif.frameTick) tick_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One vsync falling edge; pattern must hold through the tick cycle.
    task automatic frame(input int old_pat, input int new_pat);
        @(negedge clk) sif.vertSync = 1'b0;
        @(posedge clk) #1;
        check("tick_hi", int'(sif.frameTick), 1);
        check("pat_hold", int'(sif.patternSel), old_pat);
        @(posedge clk) #1;
        check("tick_lo", int'(sif.frameTick), 0);
        check("pat_new", int'(sif.patternSel), new_pat);
        repeat (2) @(negedge clk);
        sif.vertSync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_btn(input int n);
        @(negedge clk) sif.btnStep = 1'b1;
        repeat (n) @(negedge clk);
        sif.btnStep = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        sif.vertSync   = 1'b1;
        sif.swMode     = 3'd2;
        sif.autoEnable = 1'b0;
        sif.btnStep    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pat", int'(sif.patternSel), 0);
        check("rst_tick", int'(sif.frameTick), 0);
        check("rst_auto", int'(sif.autoActive), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_tick_pat", int'(sif.patternSel), 0);

        frame(0, 2);
        frame(2, 2);
        frame(2, 2);
        check("tick_count3", tick_cnt, 3);

        sif.swMode = 3'd7;
        frame(2, 0);
        sif.swMode = 3'd4;
        repeat (4) @(negedge clk);
        check("mid_frame_hold", int'(sif.patternSel), 0);
        frame(0, 4);

`ifdef PATTERN_SEQ_AUTO_CYCLE_EN
        sif.autoEnable = 1'b1;
        frame(4, 4);
        check("auto_on", int'(sif.autoActive), 1);
        frame(4, 4);
        frame(4, 4);
        frame(4, 5);
        frame(5, 5);
        frame(5, 5);
        frame(5, 0);
        frame(0, 0);
        frame(0, 0);
        frame(0, 1);

        press_btn(3);
        frame(1, 1);
        press_btn(6);
        frame(1, 2);
        frame(2, 2);
        frame(2, 2);
        frame(2, 3);

        frame(3, 3);
        frame(3, 3);
        press_btn(6);
        frame(3, 4);
        frame(4, 4);
        frame(4, 4);
        frame(4, 5);
`endif

        @(negedge clk) sif.vertSync = 1'b0;
        repeat (3) @(negedge clk);
        tick_base = tick_cnt;
        #2 rst = 1'b1;
        sif.autoEnable = 1'b0;
        #1;
        check("arst_pat", int'(sif.patternSel), 0);
        check("arst_tick", int'(sif.frameTick), 0);
        check("arst_auto", int'(sif.autoActive), 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_spurious", tick_cnt, tick_base);
        check("post_rst_pat", int'(sif.patternSel), 0);
        sif.vertSync = 1'b1;
        sif.swMode = 3'd1;
        repeat (2) @(negedge clk);
        frame(0, 1);
        check("first_real", tick_cnt, tick_base + 1);

`ifdef PATTERN_SEQ_AUTO_CYCLE_EN
        sif.autoEnable = 1'b1;
        frame(1, 1);
        check("auto_reenter", int'(sif.autoActive), 1);
        press_btn(6);
        sif.autoEnable = 1'b0;
        sif.swMode = 3'd3;
        frame(1, 3);
        check("auto_off", int'(sif.autoActive), 0);
        press_btn(6);
        sif.autoEnable = 1'b1;
        frame(3, 3);
        frame(3, 3);
        frame(3, 3);
        frame(3, 4);
`else
        sif.autoEnable = 1'b1;
        press_btn(6);
        sif.swMode = 3'd5;
        frame(1, 5);
        check("dis_auto0", int'(sif.autoActive), 0);
        sif.swMode = 3'd6;
        press_btn(6);
        frame(5, 0);
        check("dis_auto1", int'(sif.autoActive), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
